// File: rtl/feature_counter.sv
`default_nettype none
// ============================================================================
//  Module      : feature_counter
//  Description : Tick-driven modulo counter (0..MAXVAL) fed by the clock
//                divider output. Provides run/stop toggle, up/down counting,
//                synchronous clear, clamped preset load and a terminal-count
//                pulse on wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module feature_counter #(
    parameter int WIDTH  = 4,
    parameter int MAXVAL = 9
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             divClk,
    input  logic             startStop,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             upDown,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running
);

    localparam logic [WIDTH-1:0] C_MAXVAL = WIDTH'(MAXVAL);
    localparam logic [WIDTH-1:0] C_ZERO   = '0;
    localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t r_state;
    logic   r_div_clk_q;
    logic   r_start_stop_q;
    logic   w_tick;
    logic   w_ss_edge;

    // Rising-edge detection of the divider output and the run/stop request
    assign w_tick    = divClk    & ~r_div_clk_q;
    assign w_ss_edge = startStop & ~r_start_stop_q;

    // Delay registers for the two edge detectors
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_div_clk_q    <= 1'b0;
            r_start_stop_q <= 1'b0;
        end else begin
            r_div_clk_q    <= divClk;
            r_start_stop_q <= startStop;
        end
    end

    // Run/stop FSM; running is registered alongside the state so it mirrors it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_STOPPED;
            running <= 1'b0;
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    if (w_ss_edge) begin
                        r_state <= ST_RUNNING;
                        running <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (w_ss_edge) begin
                        r_state <= ST_STOPPED;
                        running <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_STOPPED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Count update in priority order clear > load > tick; tc only on a wrap.
    // The tick is judged against the pre-toggle state, so a coincident
    // run/stop edge in RUNNING still lets this step happen.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= C_ZERO;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                count <= C_ZERO;
            end else if (load) begin
                count <= (loadVal > C_MAXVAL) ? C_MAXVAL : loadVal;
            end else if (w_tick && (r_state == ST_RUNNING)) begin
                if (upDown) begin
                    if (count == C_MAXVAL) begin
                        count <= C_ZERO;
                        tc    <= 1'b1;
                    end else begin
                        count <= count + C_ONE;
                    end
                end else begin
                    if (count == C_ZERO) begin
                        count <= C_MAXVAL;
                        tc    <= 1'b1;
                    end else begin
                        count <= count - C_ONE;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_feature_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feature_counter
//  Description : Directed self-checking bench for feature_counter
//                (WIDTH=4, MAXVAL=9).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_counter;

    logic       clk;
    logic       resetN;
    logic       divClk;
    logic       startStop;
    logic       clear;
    logic       load;
    logic [3:0] loadVal;
    logic       upDown;
    logic [3:0] count;
    logic       tc;
    logic       running;

    int n_cmp;
    int n_err;

    feature_counter #(
        .WIDTH (4),
        .MAXVAL(9)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .divClk   (divClk),
        .startStop(startStop),
        .clear    (clear),
        .load     (load),
        .loadVal  (loadVal),
        .upDown   (upDown),
        .count    (count),
        .tc       (tc),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] e_cnt,
                             input logic e_tc, input logic e_run);
        chk({tag, ".count"},   32'(count),   32'(e_cnt));
        chk({tag, ".tc"},      32'(tc),      32'(e_tc));
        chk({tag, ".running"}, 32'(running), 32'(e_run));
    endtask

    // Toggle the run state with a one-cycle startStop pulse
    task automatic toggle_run();
        startStop = 1'b1;
        cyc();
        startStop = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_cnt;
        n_cmp     = 0;
        n_err     = 0;
        resetN    = 1'b0;
        divClk    = 1'b0;
        startStop = 1'b0;
        clear     = 1'b0;
        load      = 1'b0;
        loadVal   = 4'd0;
        upDown    = 1'b1;

        // ---- Reset / idle ----
        repeat (5) cyc();
        chk_state("reset", 4'd0, 1'b0, 1'b0);
        resetN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) divClk = ~divClk;
            cyc();
            chk_state("idle", 4'd0, 1'b0, 1'b0);
        end
        divClk = 1'b0;
        cyc();

        // ---- Up count with wrap ----
        startStop = 1'b1;
        cyc();
        chk("start.running", 32'(running), 32'd1);
        startStop = 1'b0;
        cyc();
        upDown  = 1'b1;
        exp_cnt = 4'd0;
        for (int i = 1; i <= 11; i++) begin
            divClk = 1'b1;
            #1;
            chk("up.latency", 32'(count), 32'(exp_cnt));
            cyc();
            exp_cnt = 4'(i % 10);
            chk("up.count", 32'(count), 32'(exp_cnt));
            chk("up.tc",    32'(tc),    32'(i == 10));
            cyc();
            chk("up.hold_count", 32'(count), 32'(exp_cnt));
            chk("up.hold_tc",    32'(tc),    32'd0);
            divClk = 1'b0;
            cyc();
        end

        // ---- Down count with wrap ----
        toggle_run();
        chk("stop.running", 32'(running), 32'd0);
        load    = 1'b1;
        loadVal = 4'd2;
        cyc();
        chk_state("load2", 4'd2, 1'b0, 1'b0);
        load = 1'b0;
        toggle_run();
        chk("down.running", 32'(running), 32'd1);
        upDown = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d_exp;
            d_exp  = (i == 0) ? 4'd1 : (i == 1) ? 4'd0 : (i == 2) ? 4'd9 : 4'd8;
            divClk = 1'b1;
            cyc();
            chk("down.count", 32'(count), 32'(d_exp));
            chk("down.tc",    32'(tc),    32'(i == 2));
            divClk = 1'b0;
            upDown = 1'b1;       // direction change between ticks is ignored
            cyc();
            chk("down.between", 32'(count), 32'(d_exp));
            upDown = 1'b0;
            cyc();
        end

        // ---- Priority and collisions ----
        load    = 1'b1;
        loadVal = 4'd15;
        cyc();
        chk_state("clamp", 4'd9, 1'b0, 1'b1);
        load   = 1'b0;
        divClk = 1'b1;
        clear  = 1'b1;
        cyc();
        chk_state("tick_clear", 4'd0, 1'b0, 1'b1);
        divClk = 1'b0;
        clear  = 1'b0;
        cyc();
        divClk  = 1'b1;         // would wrap 0->9 with tc if not overridden
        load    = 1'b1;
        loadVal = 4'd5;
        cyc();
        chk_state("tick_load", 4'd5, 1'b0, 1'b1);
        divClk = 1'b0;
        load   = 1'b0;
        cyc();

        // ---- Run/stop ----
        load    = 1'b1;
        loadVal = 4'd3;
        cyc();
        load   = 1'b0;
        upDown = 1'b1;
        cyc();
        divClk    = 1'b1;
        startStop = 1'b1;
        cyc();
        chk_state("ss_tick_run", 4'd4, 1'b0, 1'b0);
        divClk    = 1'b0;
        startStop = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            divClk = 1'b1;
            cyc();
            chk_state("stopped_tick", 4'd4, 1'b0, 1'b0);
            divClk = 1'b0;
            cyc();
        end
        divClk    = 1'b1;
        startStop = 1'b1;
        cyc();
        chk_state("ss_tick_stopped", 4'd4, 1'b0, 1'b1);
        divClk    = 1'b0;
        startStop = 1'b0;
        cyc();
        startStop = 1'b1;
        cyc();
        chk("hold_ss.first", 32'(running), 32'd0);
        repeat (9) cyc();
        chk("hold_ss.last", 32'(running), 32'd0);
        startStop = 1'b0;
        cyc();
        toggle_run();
        chk("restart.running", 32'(running), 32'd1);

        // ---- Async reset mid-run ----
        load    = 1'b1;
        loadVal = 4'd7;
        cyc();
        chk("pre_reset.count", 32'(count), 32'd7);
        load   = 1'b0;
        divClk = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        chk_state("async_reset", 4'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        resetN = 1'b1;
        cyc();
        chk_state("post_reset", 4'd0, 1'b0, 1'b0);
        startStop = 1'b1;
        cyc();
        chk_state("post_reset_run", 4'd0, 1'b0, 1'b1);
        startStop = 1'b0;
        cyc();
        chk_state("high_divclk", 4'd0, 1'b0, 1'b1);
        divClk = 1'b0;
        cyc();
        divClk = 1'b1;
        cyc();
        chk_state("post_reset_tick", 4'd1, 1'b0, 1'b1);
        divClk = 1'b0;
        cyc();

        // ---- startStop high at reset release toggles once ----
        resetN    = 1'b0;
        startStop = 1'b1;
        cyc();
        chk("rst_ss.in_reset", 32'(running), 32'd0);
        resetN = 1'b1;
        cyc();
        chk("rst_ss.first", 32'(running), 32'd1);
        cyc();
        chk("rst_ss.second", 32'(running), 32'd1);
        startStop = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
